// File: rtl/instr_cache_if.sv
// instr_cache_if: 128-bit line-fill bus between the instruction cache and instruction memory.
interface instr_cache_if;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
    modport master (output MEM_READ, MEM_ADDRESS, input MEM_READDATA, MEM_BUSYWAIT);
    modport slave (input MEM_READ, MEM_ADDRESS, output MEM_READDATA, MEM_BUSYWAIT);
endinterface

// File: rtl/instr_cache.sv
// instr_cache: direct-mapped read-only instruction cache, combinational hits, 16-byte line fill on miss.
module instr_cache #(
    parameter int          INDEX_BITS = 3,
    parameter logic [31:0] NOP_INSN   = 32'h00000013
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [31:0]   ADDRESS,
    output logic [31:0]   INSTRUCTION,
    output logic          BUSYWAIT,
    instr_cache_if.master mem
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;
    typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;
    state_t                state;
    logic [LINES-1:0]      valid;
    logic [TAG_BITS-1:0]   tags [LINES];
    logic [127:0]          data [LINES];
    logic [INDEX_BITS-1:0] index;
    logic [INDEX_BITS-1:0] fill_index;
    logic [TAG_BITS-1:0]   tag;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  hit;
    logic                  fill_done;
    logic                  unused_offset;
    assign index         = ADDRESS[4 +: INDEX_BITS];
    assign tag           = ADDRESS[31 -: TAG_BITS];
    assign fill_index    = mem.MEM_ADDRESS[INDEX_BITS-1:0];
    assign fill_tag      = mem.MEM_ADDRESS[27 -: TAG_BITS];
    assign fill_done     = state == MEM_READ && !mem.MEM_BUSYWAIT;
    assign unused_offset = ^ADDRESS[1:0];
    // Outputs are gated by RESET so the CPU sees no stall while reset is held.
    always_comb begin
        hit         = valid[index] && tags[index] == tag;
        BUSYWAIT    = RESET && (state != IDLE || !hit);
        INSTRUCTION = RESET && state == IDLE && hit ? data[index][32*ADDRESS[3:2] +: 32] : NOP_INSN;
    end
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state           <= IDLE;
            valid           <= '0;
            mem.MEM_READ    <= 1'b0;
            mem.MEM_ADDRESS <= '0;
        end else if (state == IDLE) begin
            if (!hit) begin
                state           <= MEM_READ;
                mem.MEM_READ    <= 1'b1;
                mem.MEM_ADDRESS <= ADDRESS[31:4];
            end
        end else if (state == MEM_READ) begin
            if (fill_done) begin
                state             <= UPDATE;
                mem.MEM_READ      <= 1'b0;
                valid[fill_index] <= 1'b1;
            end
        end else begin
            state <= IDLE;
        end
    end
    // Tag and data arrays carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (fill_done) begin
            tags[fill_index] <= fill_tag;
            data[fill_index] <= mem.MEM_READDATA;
        end
    end
endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped, read-only instruction cache placed directly upstream of the CPU IF stage.
- Consumes the fetch PC and returns INSTRUCTION with INSTR_MEM_BUSYWAIT semantics.
- On a miss, fetches a 16-byte line (four words) from instruction main memory over a 128-bit block interface.
- Hits are served combinationally in the same cycle. Misses hold BUSYWAIT until the line is installed.

Parameters:
- INDEX_BITS, 3, log2 of the number of cache lines (default 8 lines).
- NOP_INSN, 32'h00000013, value driven on INSTRUCTION during a miss or reset (ADDI x0,x0,0).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RESET  input  1  asynchronous, active-low reset.
- ADDRESS  input  32  fetch PC from the CPU. Bits [1:0] are ignored.
- INSTRUCTION  output  32  fetched instruction word to the IF/ID register.
- BUSYWAIT  output  1  stall request to the CPU; drives INSTR_MEM_BUSYWAIT.
- MEM_READ  output  1  block read request to instruction memory.
- MEM_ADDRESS  output  28  block address, equal to ADDRESS[31:4] of the missing line.
- MEM_READDATA  input  128  line data; word w sits at bits [32w+31:32w].
- MEM_BUSYWAIT  input  1  memory busy. Data is valid in the cycle it is low while MEM_READ=1.

Behaviour:
- Address split:
  - offset = ADDRESS[3:2]
  - index = ADDRESS[4+INDEX_BITS-1:4]
  - tag = ADDRESS[31:4+INDEX_BITS] (25 bits at default)
- Per-line storage: valid bit, tag, 128-bit data.
- Hit = valid[index] AND (tag match). Evaluated combinationally from ADDRESS.
- Reset (RESET=0, asynchronous):
  - all valid bits cleared; state goes to IDLE.
  - MEM_READ=0, MEM_ADDRESS=0, BUSYWAIT=0, INSTRUCTION=NOP_INSN while asserted.
  - Tag and data arrays are not cleared.
- FSM states: IDLE, MEM_READ, UPDATE.
- IDLE:
  - Hit: INSTRUCTION = data[index] word at offset, BUSYWAIT=0. No state change.
  - Miss: BUSYWAIT=1 combinationally in the same cycle, INSTRUCTION=NOP_INSN.
  - On a miss, the next posedge latches {tag,index} into a miss register and moves to MEM_READ.
- MEM_READ:
  - MEM_READ=1, MEM_ADDRESS = latched {tag,index}, BUSYWAIT=1, INSTRUCTION=NOP_INSN.
  - At a posedge with MEM_BUSYWAIT=0: write MEM_READDATA into line[latched index], set its tag, set valid=1, go to UPDATE.
  - Otherwise stay in MEM_READ.
- UPDATE:
  - MEM_READ=0, BUSYWAIT=1, INSTRUCTION=NOP_INSN.
  - Unconditionally returns to IDLE on the next posedge. The access then re-evaluates and hits.
- Miss latency: BUSYWAIT is high for exactly k+2 cycles, where k is the number of cycles spent in MEM_READ (k≥1).
- ADDRESS is required stable while BUSYWAIT=1.
  - If it changes anyway, the fill still completes for the latched line.
  - The new address is evaluated only on return to IDLE.
- Replacement: a miss unconditionally overwrites the indexed line. No write path and no dirty state exist.
- MEM_ADDRESS holds its last value when MEM_READ=0. Memory must qualify it with MEM_READ.
- Reset mid-fill: the in-flight request is dropped (MEM_READ falls asynchronously) and the line is not installed. After release, the same address misses again.
- MEM_READDATA is sampled only in MEM_READ with MEM_BUSYWAIT=0. Its value is ignored in all other cycles.

Test Plan:
- Cold miss: release reset, ADDRESS=0x00000000. Memory model holds MEM_BUSYWAIT=1 for 3 MEM_READ cycles, then returns line {0x00C00093,0x00800093,0x00400093,0x00000093} (word3..word0).
  - Required: MEM_READ=1 with MEM_ADDRESS=0x0000000.
  - BUSYWAIT high exactly 6 cycles (k=4), INSTRUCTION=0x00000013 throughout.
  - Then BUSYWAIT=0 and INSTRUCTION=0x00000093.
- Sequential hits: after the cold miss, ADDRESS=0x4, 0x8, 0xC on consecutive cycles.
  - Required: INSTRUCTION=0x00400093, 0x00800093, 0x00C00093.
  - BUSYWAIT=0 every cycle; MEM_READ never asserts.
- Conflict eviction: ADDRESS=0x80 (same index 0, tag 1) causes a miss and fill with MEM_ADDRESS=0x0000008. Then ADDRESS=0x0 misses again with MEM_ADDRESS=0x0000000.
- Zero-latency memory: MEM_BUSYWAIT=0 in the first MEM_READ cycle.
  - Required: BUSYWAIT high exactly 3 cycles, correct word afterwards.
- Reset mid-fill: drive RESET low during the second MEM_READ cycle for ADDRESS=0x40.
  - Required: MEM_READ=0 and BUSYWAIT=0 immediately, without waiting for a clock edge.
  - After release, 0x40 misses again (MEM_ADDRESS=0x0000004). A previously cached 0x0 also misses.
- Unaligned low bits: ADDRESS=0x00000006 after the line is cached returns the word at 0x4 (0x00400093) with BUSYWAIT=0.
